// File: rtl/ram_responder.sv
// ---------------------------------------------------------------------------
// ram_responder : 8K x 16 CPU-side RAM with boot loader fill port and a
//                 memory-mapped watch register for observing CPU stores.
// Revision      : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ram_responder #(
  parameter int                ADDR_W     = 13,
  parameter int                DATA_W     = 16,
  parameter int                DEPTH      = 8192,
  parameter logic [ADDR_W-1:0] WATCH_ADDR = 13'h1FFF,
  parameter bit                BOOT_LOAD  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_toRAM,
  input  logic [DATA_W-1:0] data_toRAM,
  input  logic              wrEn,
  output logic [DATA_W-1:0] data_fromRAM,
  output logic              cpu_rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic [ADDR_W:0]   ld_count,
  output logic [DATA_W-1:0] watch_data,
  output logic              watch_strobe
);

  typedef enum logic [1:0] {
    S_LOAD     = 2'd0,
    S_RUN_WAIT = 2'd1,
    S_RUN      = 2'd2
  } state_t;

  localparam state_t          c_RESET_STATE = BOOT_LOAD ? S_LOAD : S_RUN_WAIT;
  localparam logic [ADDR_W:0] c_CNT_MAX     = '1;

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  state_t            w_state_next;
  logic              r_ld_ready;
  logic              r_cpu_rst;
  logic [ADDR_W:0]   r_ld_count;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_watch_data;
  logic              r_watch_strobe;

  logic              w_hs;
  logic              w_cpu_we;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  // ld_ready is only ever high in LOAD, so it also gates the loader write
  assign w_hs     = r_ld_ready & ld_valid;
  assign w_cpu_we = (r_state == S_RUN) & wrEn;
  assign w_we     = w_hs | w_cpu_we;
  assign w_waddr  = w_hs ? ld_addr : addr_toRAM;
  assign w_wdata  = w_hs ? ld_data : data_toRAM;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD:     if (w_hs && ld_last) w_state_next = S_RUN_WAIT;
      S_RUN_WAIT: w_state_next = S_RUN;
      S_RUN:      w_state_next = S_RUN;
      default:    w_state_next = c_RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_RESET_STATE;
    else      r_state <= w_state_next;
  end

  // Array deliberately has no reset so loaded code survives a CPU reset
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata        <= '0;
      r_ld_ready     <= 1'b0;
      r_cpu_rst      <= 1'b1;
      r_ld_count     <= '0;
      r_watch_data   <= '0;
      r_watch_strobe <= 1'b0;
    end else begin
      r_rdata        <= (w_we && (w_waddr == addr_toRAM)) ? w_wdata : r_mem[addr_toRAM];
      r_ld_ready     <= (w_state_next == S_LOAD);
      // Lags the state by one edge so the CPU sees a reset edge after RUN_WAIT
      r_cpu_rst      <= (r_state != S_RUN);
      r_watch_strobe <= 1'b0;
      if (w_hs && (r_ld_count != c_CNT_MAX)) r_ld_count <= r_ld_count + 1'b1;
      if (w_cpu_we && (addr_toRAM == WATCH_ADDR)) begin
        r_watch_data   <= data_toRAM;
        r_watch_strobe <= 1'b1;
      end
    end
  end

  assign data_fromRAM = r_rdata;
  assign ld_ready     = r_ld_ready;
  assign cpu_rst      = r_cpu_rst;
  assign ld_count     = r_ld_count;
  assign watch_data   = r_watch_data;
  assign watch_strobe = r_watch_strobe;

endmodule

`default_nettype wire

// File: tb/tb_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_ram_responder : scoreboard bench for ram_responder (BOOT_LOAD=1 and 0).
// Revision         : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] addr_toRAM;
  logic [15:0] data_toRAM;
  logic        wrEn;
  logic        ld_valid;
  logic [12:0] ld_addr;
  logic [15:0] ld_data;
  logic        ld_last;

  logic [15:0] data_fromRAM, watch_data;
  logic        cpu_rst, ld_ready, watch_strobe;
  logic [13:0] ld_count;

  logic [15:0] d0_rdata, d0_watch;
  logic        d0_cpu_rst, d0_ld_ready, d0_strobe;
  logic [13:0] d0_count;

  always #5 clk = ~clk;

  ram_responder #(.BOOT_LOAD(1'b1)) dut (
    .clk(clk), .rst(rst), .addr_toRAM(addr_toRAM), .data_toRAM(data_toRAM),
    .wrEn(wrEn), .data_fromRAM(data_fromRAM), .cpu_rst(cpu_rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last), .ld_count(ld_count),
    .watch_data(watch_data), .watch_strobe(watch_strobe)
  );

  ram_responder #(.BOOT_LOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .addr_toRAM(addr_toRAM), .data_toRAM(data_toRAM),
    .wrEn(wrEn), .data_fromRAM(d0_rdata), .cpu_rst(d0_cpu_rst),
    .ld_valid(ld_valid), .ld_ready(d0_ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last), .ld_count(d0_count),
    .watch_data(d0_watch), .watch_strobe(d0_strobe)
  );

  typedef struct {
    bit          chk_rd;
    logic [15:0] rd;
    logic [15:0] watch;
    logic        strobe;
    logic        cpu_rst;
    logic        ready;
    logic [13:0] cnt;
    logic        cpu_rst0;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: memory contents plus "edges since loading finished"
  logic [15:0] m_mem [logic [12:0]];
  bit          m_done;
  int          m_since;
  int          m_since0;
  bit          m_ready;
  logic [13:0] m_cnt;
  logic [15:0] m_watch;
  bit          m_strobe;
  bit          m_hs;

  task automatic model_step();
    exp_t e;
    bit   cpu_we;
    bit   we;
    logic [12:0] wa;
    logic [15:0] wd;
    m_hs = 1'b0;
    if (!rst) begin
      m_done = 1'b0; m_since = 0; m_since0 = 0; m_ready = 1'b0;
      m_cnt = '0; m_watch = '0; m_strobe = 1'b0;
      e.chk_rd = 1'b1; e.rd = '0;
    end else begin
      cpu_we = m_done && (m_since >= 1) && wrEn;
      m_hs   = m_ready && ld_valid;
      we = cpu_we || m_hs;
      wa = m_hs ? ld_addr : addr_toRAM;
      wd = m_hs ? ld_data : data_toRAM;
      if (we && wa == addr_toRAM) begin
        e.chk_rd = 1'b1; e.rd = wd;
      end else if (m_mem.exists(addr_toRAM)) begin
        e.chk_rd = 1'b1; e.rd = m_mem[addr_toRAM];
      end else begin
        e.chk_rd = 1'b0; e.rd = '0;
      end
      if (we) m_mem[wa] = wd;
      m_strobe = cpu_we && (addr_toRAM == 13'h1FFF);
      if (m_strobe) m_watch = data_toRAM;
      if (m_hs && m_cnt != 14'h3FFF) m_cnt = m_cnt + 14'd1;
      if (m_hs && ld_last) begin
        m_done = 1'b1; m_since = 0;
      end else if (m_done) begin
        m_since++;
      end
      m_ready = !m_done;
      m_since0++;
    end
    e.watch    = m_watch;
    e.strobe   = m_strobe;
    e.ready    = m_ready;
    e.cnt      = m_cnt;
    e.cpu_rst  = !(m_done && m_since >= 2);
    e.cpu_rst0 = !rst || (m_since0 < 2);
    q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic v, input logic [12:0] la,
                     input logic [15:0] ldd, input logic lst, input logic we,
                     input logic [12:0] a, input logic [15:0] d);
    @(negedge clk);
    rst = r; ld_valid = v; ld_addr = la; ld_data = ldd; ld_last = lst;
    wrEn = we; addr_toRAM = a; data_toRAM = d;
    model_step();
  endtask

  task automatic cpu(input logic we, input logic [12:0] a, input logic [15:0] d);
    cyc(1'b1, 1'b0, 13'($urandom_range(0, 7)), 16'($urandom), 1'($urandom), we, a, d);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Holds the word until the model says it was accepted; CPU writes are junk
  task automatic ld_word(input logic [12:0] a, input logic [15:0] d, input logic lst);
    int tries = 0;
    do begin
      cyc(1'b1, 1'b1, a, d, lst, 1'($urandom), 13'($urandom_range(0, 7)), 16'($urandom));
      tries++;
    end while (!m_hs && tries < 8);
    if (!m_hs) begin
      n_cmp++; n_bad++;
      $display("FAIL ld_accept: word for addr %h not accepted after %0d cycles", a, tries);
    end
  endtask

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_rd) chk("data_fromRAM", data_fromRAM, e.rd);
        chk("watch_data", watch_data, e.watch);
        chk("watch_strobe", {15'd0, watch_strobe}, {15'd0, e.strobe});
        chk("cpu_rst", {15'd0, cpu_rst}, {15'd0, e.cpu_rst});
        chk("ld_ready", {15'd0, ld_ready}, {15'd0, e.ready});
        chk("ld_count", {2'd0, ld_count}, {2'd0, e.cnt});
        chk("noboot_cpu_rst", {15'd0, d0_cpu_rst}, {15'd0, e.cpu_rst0});
        chk("noboot_ld_ready", {15'd0, d0_ld_ready}, 16'd0);
        chk("noboot_ld_count", {2'd0, d0_count}, 16'd0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin : stimulus
    rst = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    wrEn = 1'b0; addr_toRAM = '0; data_toRAM = '0;
    do_reset(2);

    // Boot load, including a loader write to the watch address
    ld_word(13'h0000, 16'hC005, 1'b0);
    cyc(1'b1, 1'b0, 13'h0003, 16'hFFFF, 1'b1, 1'b0, 13'h0000, 16'h0);
    ld_word(13'h0001, 16'hE006, 1'b0);
    ld_word(13'h1FFF, 16'h7777, 1'b0);
    ld_word(13'h0005, 16'h1234, 1'b1);

    // Directed run-phase traffic
    cpu(1'b0, 13'h0000, 16'h0);
    cpu(1'b0, 13'h0005, 16'h0);
    cpu(1'b0, 13'h0001, 16'h0);
    cpu(1'b1, 13'h0006, 16'hBEEF);
    cpu(1'b0, 13'h0006, 16'h0);
    cpu(1'b1, 13'h1FFF, 16'h00A5);
    cpu(1'b1, 13'h1FFF, 16'h5A00);
    cpu(1'b0, 13'h1FFF, 16'h0);
    cpu(1'b0, 13'h0006, 16'h0);

    // Randomized run-phase traffic over a small address window
    for (int i = 0; i < 300; i++) begin
      int sel = $urandom_range(0, 9);
      cpu(1'($urandom), (sel == 9) ? 13'h1FFF : 13'(sel), 16'($urandom));
    end

    // Reset mid-run, then reset again mid-load after two words
    do_reset(2);
    ld_word(13'h0002, 16'h1111, 1'b0);
    ld_word(13'h0003, 16'h2222, 1'b0);
    do_reset(2);
    ld_word(13'h0002, 16'h3333, 1'b0);
    ld_word(13'h0003, 16'h4444, 1'b0);
    ld_word(13'h0004, 16'h5555, 1'b0);
    ld_word(13'h0007, 16'h6666, 1'b1);
    for (int a = 0; a < 9; a++) cpu(1'b0, (a == 8) ? 13'h1FFF : 13'(a), 16'h0);
    for (int i = 0; i < 100; i++) begin
      int sel = $urandom_range(0, 9);
      cpu(1'($urandom), (sel == 9) ? 13'h1FFF : 13'(sel), 16'($urandom));
    end

    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the CPU's single-port RAM interface: address, write data and write enable in; read data out.
- Holds an 8K x 16 word array with one-cycle registered read latency. This matches the CPU's fetch timing: address driven in one state, data consumed in the next.
- Adds a boot loader port (valid/ready) that fills memory while the CPU is held in reset.
- Adds a memory-mapped watch register for testbench/debug observation of CPU stores.

Parameters:
ADDR_W, 13, address width of the CPU interface
DATA_W, 16, word width
DEPTH, 8192, number of words (2^ADDR_W)
WATCH_ADDR, 13'h1FFF, address whose CPU writes are mirrored to watch_data
BOOT_LOAD, 1, 1: start in LOAD state after reset; 0: go straight to RUN

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
addr_toRAM  input  13  CPU address
data_toRAM  input  16  CPU write data
wrEn  input  1  CPU write enable, sampled at clk edge
data_fromRAM  output  16  registered read data to CPU
cpu_rst  output  1  active-high synchronous reset to drive the CPU's rst
ld_valid  input  1  loader word valid
ld_ready  output  1  responder accepts loader word
ld_addr  input  13  loader target address
ld_data  input  16  loader word
ld_last  input  1  final loader word (qualified by ld_valid)
ld_count  output  14  number of loader words accepted since reset
watch_data  output  16  last value the CPU wrote to WATCH_ADDR
watch_strobe  output  1  one-cycle pulse when watch_data updates

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - data_fromRAM=0, watch_data=0, watch_strobe=0, ld_count=0, ld_ready=0, cpu_rst=1.
  - state = LOAD if BOOT_LOAD=1, else RUN_WAIT.
  - The memory array is not reset; contents persist across reset.
- States: LOAD, RUN_WAIT, RUN. State encoding is registered.
- LOAD:
  - ld_ready=1 (registered; first asserted on the first clk edge after rst deasserts). cpu_rst=1.
  - Handshake at a clk edge with ld_valid=1 and ld_ready=1:
    - mem[ld_addr] <= ld_data.
    - ld_count increments, saturating at 14'h3FFF.
  - If ld_last is also 1 on that handshake: next state RUN_WAIT, and ld_ready drops to 0 on the same edge.
  - ld_valid=0: no write, no count change. CPU wrEn is ignored in LOAD.
- RUN_WAIT: one cycle with cpu_rst=1, then RUN. This guarantees the CPU samples at least one reset edge after the last loaded word.
- RUN:
  - cpu_rst=0, ld_ready=0; loader inputs are ignored.
  - Stays in RUN until rst is asserted.
- Read path, all states:
  - data_fromRAM <= mem[addr_toRAM] at every clk edge (1-cycle latency).
  - Read-during-write to the same address, CPU write in RUN or loader write in LOAD: data_fromRAM gets the new write data (write-first).
- CPU write, RUN only: wrEn=1 at a clk edge writes mem[addr_toRAM] <= data_toRAM.
- Watch register:
  - A CPU write with addr_toRAM==WATCH_ADDR also sets watch_data <= data_toRAM and watch_strobe <= 1 for exactly one cycle.
  - The memory word is written too.
  - Back-to-back watch writes give consecutive strobes.
  - Loader writes to WATCH_ADDR do not update watch_data or watch_strobe.
- Address wrap: addresses are full 13-bit, and DEPTH=2^ADDR_W, so no out-of-range case exists.
- Reset mid-load: loading aborts, ld_count returns to 0, and already-written words remain. Loading restarts from LOAD.
- Reset mid-run: cpu_rst asserts asynchronously, memory is untouched, and BOOT_LOAD decides whether LOAD re-enters.
- ld_last with ld_valid=0 has no effect.

Test Plan:
- Reset, then load 3 words (addr 0: 16'hC005, addr 1: 16'hE006, addr 5: 16'h1234, last) -> ld_count=3. cpu_rst deasserts exactly 2 edges after the last handshake. ld_ready=0 afterwards.
- RUN, CPU reads addr 5 -> data_fromRAM=16'h1234 one cycle after addr_toRAM=5, not in the same cycle.
- RUN, wrEn=1, addr 6, data 16'hBEEF, while also reading addr 6 -> data_fromRAM=16'hBEEF at the next edge. A later read of addr 6 also returns 16'hBEEF.
- RUN, CPU writes 16'h00A5 to 13'h1FFF -> watch_data=16'h00A5, watch_strobe high for one cycle. A loader-era write to 13'h1FFF leaves watch_data=0.
- Assert rst after 2 of 4 loader words -> ld_count=0, ld_ready=0 during reset. After release, the reloaded sequence completes and earlier words are still readable.
- BOOT_LOAD=0 -> ld_ready never asserts, and cpu_rst deasserts 2 edges after rst release.
